// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle RISC-V control unit:
// FSM state enum, opcode values, ALU operation codes and mux selects.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ERR      = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_CUSTOM = 7'b0001011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BEQ    = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_SLT  = 5'b00101;
    localparam logic [4:0] ALU_ANDN = 5'b10000;
    localparam logic [4:0] ALU_ORN  = 5'b10001;
    localparam logic [4:0] ALU_XNOR = 5'b10010;
    localparam logic [4:0] ALU_MIN  = 5'b10011;
    localparam logic [4:0] ALU_MAX  = 5'b10100;
    localparam logic [4:0] ALU_MINU = 5'b10101;
    localparam logic [4:0] ALU_MAXU = 5'b10110;
    localparam logic [4:0] ALU_ROL  = 5'b10111;
    localparam logic [4:0] ALU_ROR  = 5'b11000;
    localparam logic [4:0] ALU_ABS  = 5'b11001;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Successor of DECODE; unknown opcodes trap into ERR.
    function automatic state_t decode_next(input logic [6:0] op);
        state_t nxt;
        case (op)
            OP_LW, OP_SW:         nxt = S_MEMADR;
            OP_RTYPE, OP_CUSTOM:  nxt = S_EXECR;
            OP_ITYPE:             nxt = S_EXECI;
            OP_BEQ:               nxt = S_BEQ;
            OP_JAL:               nxt = S_JAL;
            default:              nxt = S_ERR;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps (op, funct3, funct7) to an ALUControl code and a
// valid bit. Ports: op, funct3, funct7 in; alu_ctrl, valid out.
module mc_aludec
    import mc_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [4:0] alu_ctrl,
    output logic       valid
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        valid    = 1'b0;
        case (op)
            OP_RTYPE, OP_ITYPE: begin
                valid = 1'b1;
                case (funct3)
                    // op[5] separates register from immediate form;
                    // only the register form may subtract.
                    3'b000:  alu_ctrl = (op[5] & funct7[5]) ? ALU_SUB
                                                            : ALU_ADD;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b110:  alu_ctrl = ALU_OR;
                    3'b111:  alu_ctrl = ALU_AND;
                    default: valid = 1'b0;
                endcase
            end
            OP_CUSTOM: begin
                valid = 1'b1;
                case ({funct7, funct3})
                    10'b0000000_000: alu_ctrl = ALU_ANDN;
                    10'b0000000_001: alu_ctrl = ALU_ORN;
                    10'b0000000_010: alu_ctrl = ALU_XNOR;
                    10'b0000001_000: alu_ctrl = ALU_MIN;
                    10'b0000001_001: alu_ctrl = ALU_MAX;
                    10'b0000001_010: alu_ctrl = ALU_MINU;
                    10'b0000001_011: alu_ctrl = ALU_MAXU;
                    10'b0000010_000: alu_ctrl = ALU_ROL;
                    10'b0000010_001: alu_ctrl = ALU_ROR;
                    10'b0000011_000: alu_ctrl = ALU_ABS;
                    default:         valid = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM with unified-memory handshake.
// In: clk, reset, op, funct3, funct7, Zero, mem_ready.
// Out: datapath enables/selects, ALUControl, illegal, instret, state.
module multicycle_ctrl
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [4:0]  ALUControl,
    output logic        illegal,
    output logic [31:0] instret,
    output logic [3:0]  state
);

    state_t     cur;
    logic [4:0] dec_alu;
    logic       dec_valid;
    logic       retire;

    mc_aludec u_aludec (
        .op       (op),
        .funct3   (funct3),
        .funct7   (funct7),
        .alu_ctrl (dec_alu),
        .valid    (dec_valid)
    );

    assign state = cur;

    // An instruction retires on the last transition back to FETCH.
    assign retire = (cur == S_MEMWB)
                  | (cur == S_ALUWB)
                  | (cur == S_BEQ)
                  | ((cur == S_MEMWRITE) & mem_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur     <= S_FETCH;
            instret <= '0;
        end else begin
            unique case (cur)
                S_FETCH:
                    if (mem_ready) cur <= S_DECODE;
                S_DECODE:
                    cur <= decode_next(op);
                S_MEMADR:
                    cur <= op[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:
                    if (mem_ready) cur <= S_MEMWB;
                S_MEMWB:
                    cur <= S_FETCH;
                S_MEMWRITE:
                    if (mem_ready) cur <= S_FETCH;
                S_EXECR, S_EXECI:
                    cur <= dec_valid ? S_ALUWB : S_ERR;
                S_ALUWB:
                    cur <= S_FETCH;
                S_BEQ:
                    cur <= S_FETCH;
                S_JAL:
                    cur <= S_ALUWB;
                S_ERR:
                    cur <= S_ERR;
                default:
                    cur <= S_ERR;
            endcase
            if (retire) instret <= instret + 32'd1;
        end
    end

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ImmSrc     = IMM_I;
        ALUControl = ALU_ADD;
        illegal    = 1'b0;
        unique case (cur)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_B;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = op[5] ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_RS1;
                ALUControl = dec_alu;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                ALUControl = dec_alu;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA    = SRCA_RS1;
                ALUControl = ALU_SUB;
                PCWrite    = Zero;
            end
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                ImmSrc  = IMM_J;
                PCWrite = 1'b1;
            end
            S_ERR: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        // FETCH is Mealy on mem_ready, so the async reset alone
        // would not keep the enables quiet while reset is held.
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instruction
// scenarios followed by randomized instructions and memory stalls.
module tb_multicycle_ctrl;
    import mc_pkg::*;

    logic        clk;
    logic        reset;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        Zero;
    logic        mem_ready;
    logic        PCWrite;
    logic        AdrSrc;
    logic        IRWrite;
    logic        RegWrite;
    logic        MemWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ImmSrc;
    logic [4:0]  ALUControl;
    logic        illegal;
    logic [31:0] instret;
    logic [3:0]  state;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_instret = '0;
    bit          last_err;

    localparam logic [9:0] CUST_KEYS [10] = '{
        10'b0000000000, 10'b0000000001, 10'b0000000010,
        10'b0000001000, 10'b0000001001, 10'b0000001010,
        10'b0000001011, 10'b0000010000, 10'b0000010001,
        10'b0000011000
    };

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7     (funct7),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .illegal    (illegal),
        .instret    (instret),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference ALU decode: table lookup for the custom opcode,
    // funct3 rules for the base arithmetic opcodes.
    function automatic void exp_alu(input logic [6:0] o,
                                    input logic [2:0] f3,
                                    input logic [6:0] f7,
                                    output logic ok,
                                    output logic [4:0] a);
        ok = 1'b0;
        a  = 5'd0;
        if (o == 7'b0001011) begin
            for (int i = 0; i < 10; i++) begin
                if ({f7, f3} == CUST_KEYS[i]) begin
                    ok = 1'b1;
                    a  = 5'(16 + i);
                end
            end
        end else if (o == 7'b0110011 || o == 7'b0010011) begin
            ok = 1'b1;
            case (f3)
                3'b000:  a = (o == 7'b0110011 && f7[5]) ? 5'd1 : 5'd0;
                3'b010:  a = 5'd5;
                3'b110:  a = 5'd3;
                3'b111:  a = 5'd2;
                default: ok = 1'b0;
            endcase
        end
    endfunction

    task automatic check_outputs(input state_t st, input logic mr,
                                 input logic z, input logic [6:0] o,
                                 input logic ok, input logic [4:0] a);
        logic pcw, irw, rw, mw, adr, ill, alu_chk;
        logic [1:0] res, sa, sb, imm;
        logic [4:0] alu;
        pcw = 0; irw = 0; rw = 0; mw = 0; adr = 0; ill = 0;
        res = 0; sa = 0; sb = 0; imm = 0; alu = 0; alu_chk = 1;
        case (st)
            S_FETCH:    begin sb = 2; res = 2; irw = mr; pcw = mr; end
            S_DECODE:   begin sa = 1; sb = 1; imm = 2; end
            S_MEMADR:   begin sa = 2; sb = 1;
                              imm = (o == 7'b0100011) ? 2'd1 : 2'd0; end
            S_MEMREAD:  adr = 1;
            S_MEMWB:    begin res = 1; rw = 1; end
            S_MEMWRITE: begin adr = 1; mw = 1; end
            S_EXECR:    begin sa = 2; alu = a; alu_chk = ok; end
            S_EXECI:    begin sa = 2; sb = 1; alu = a; alu_chk = ok; end
            S_ALUWB:    rw = 1;
            S_BEQ:      begin sa = 2; alu = 5'd1; pcw = z; end
            S_JAL:      begin sa = 1; sb = 2; imm = 3; pcw = 1; end
            S_ERR:      ill = 1;
            default:    ill = 1;
        endcase
        chk($sformatf("state[%s]", st.name()), 32'(state), 32'(st));
        chk($sformatf("we[%s]", st.name()),
            {PCWrite, IRWrite, RegWrite, MemWrite},
            {pcw, irw, rw, mw});
        chk($sformatf("sel[%s]", st.name()),
            {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc},
            {adr, res, sa, sb, imm});
        if (alu_chk)
            chk($sformatf("alu[%s]", st.name()), 32'(ALUControl), 32'(alu));
        chk($sformatf("illegal[%s]", st.name()), 32'(illegal), 32'(ill));
        chk($sformatf("instret[%s]", st.name()), instret, exp_instret);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("rst_state", 32'(state), 32'(S_FETCH));
        chk("rst_instret", instret, 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_we", {PCWrite, IRWrite, RegWrite, MemWrite}, 32'd0);
        @(negedge clk);
        mem_ready   = 1'b0;
        reset       = 1'b0;
        exp_instret = '0;
    endtask

    // Walks one instruction through its expected state path. Stall
    // counts < 0 pick random stalls; ERR paths are observed 10 cycles.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3,
                             input logic [6:0] f7, input logic z,
                             input int st_fetch, input int st_mem,
                             input bit abort_memread);
        logic       ok;
        logic [4:0] a;
        state_t     path[$];
        state_t     st;
        logic       mr;
        bit         stall_st;
        int         idx, waitc, lim, budget, errc;
        op = o; funct3 = f3; funct7 = f7; Zero = z;
        exp_alu(o, f3, f7, ok, a);
        path = '{S_FETCH, S_DECODE};
        case (o)
            7'b0000011: begin
                path.push_back(S_MEMADR);
                path.push_back(S_MEMREAD);
                path.push_back(S_MEMWB);
            end
            7'b0100011: begin
                path.push_back(S_MEMADR);
                path.push_back(S_MEMWRITE);
            end
            7'b0110011, 7'b0001011: begin
                path.push_back(S_EXECR);
                path.push_back(ok ? S_ALUWB : S_ERR);
            end
            7'b0010011: begin
                path.push_back(S_EXECI);
                path.push_back(ok ? S_ALUWB : S_ERR);
            end
            7'b1100011: path.push_back(S_BEQ);
            7'b1101111: begin
                path.push_back(S_JAL);
                path.push_back(S_ALUWB);
            end
            default: path.push_back(S_ERR);
        endcase
        last_err = (path[path.size()-1] == S_ERR);
        idx = 0; waitc = 0; lim = 0; budget = 0; errc = 0;
        while (idx < path.size()) begin
            st = path[idx];
            stall_st = (st == S_FETCH) || (st == S_MEMREAD)
                    || (st == S_MEMWRITE);
            if (waitc == 0) begin
                lim = (st == S_FETCH) ? st_fetch : st_mem;
                if (lim < 0) lim = $urandom_range(0, 2);
            end
            @(negedge clk);
            mr = stall_st ? (waitc >= lim) : 1'($urandom_range(0, 1));
            mem_ready = mr;
            #1;
            check_outputs(st, mr, z, o, ok, a);
            if (abort_memread && st == S_MEMREAD) return;
            budget++;
            if (budget > 100) begin
                checks++;
                failures++;
                $error("FAIL timeout op=%b idx=%0d", o, idx);
                return;
            end
            if (st == S_ERR) begin
                errc++;
                if (errc >= 10) break;
                @(posedge clk);
                continue;
            end
            @(posedge clk);
            if (stall_st && !mr) begin
                waitc++;
            end else begin
                if (st == S_MEMWB || st == S_ALUWB ||
                    st == S_BEQ || st == S_MEMWRITE)
                    exp_instret++;
                idx++;
                waitc = 0;
            end
        end
    endtask

    initial begin
        logic [6:0] ops [8];
        logic [6:0] o, f7;
        logic [2:0] f3;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b0001011, 7'b1100011, 7'b1101111, 7'b1100111};
        op = '0; funct3 = '0; funct7 = '0; Zero = 1'b0;
        mem_ready = 1'b0; reset = 1'b1;
        do_reset();

        run_instr(7'b0000011, 3'b010, 7'd0, 1'b0, 0, 0, 0);
        #1 chk("lw_instret", instret, 32'd1);

        run_instr(7'b1100011, 3'b000, 7'd0, 1'b1, 0, 0, 0);
        run_instr(7'b1100011, 3'b000, 7'd0, 1'b0, 0, 0, 0);
        #1 chk("beq_instret", instret, 32'd3);

        run_instr(7'b0001011, 3'b001, 7'b0000010, 1'b0, 0, 0, 0);
        run_instr(7'b0001011, 3'b000, 7'b0000011, 1'b0, 0, 0, 0);
        run_instr(7'b0001011, 3'b000, 7'b0000100, 1'b0, 0, 0, 0);
        do_reset();

        run_instr(7'b0110011, 3'b000, 7'b0000000, 1'b0, 3, 0, 0);
        run_instr(7'b0110011, 3'b000, 7'b0100000, 1'b0, 0, 0, 0);
        run_instr(7'b0010011, 3'b000, 7'b0100000, 1'b0, 0, 0, 0);
        run_instr(7'b0010011, 3'b110, 7'd0, 1'b0, 0, 0, 0);
        run_instr(7'b0110011, 3'b010, 7'd0, 1'b0, 0, 0, 0);
        run_instr(7'b1101111, 3'b000, 7'd0, 1'b0, 0, 0, 0);
        run_instr(7'b0100011, 3'b010, 7'd0, 1'b0, 0, 2, 0);
        #1 chk("sw_instret", instret, 32'd7);
        run_instr(7'b0110011, 3'b001, 7'd0, 1'b0, 0, 0, 0);
        do_reset();
        run_instr(7'b1110011, 3'b000, 7'd0, 1'b0, 0, 0, 0);
        do_reset();

        for (int i = 0; i < 5; i++)
            run_instr(7'b0000011, 3'b010, 7'd0, 1'b0, 0, 0, 0);
        run_instr(7'b0000011, 3'b010, 7'd0, 1'b0, 0, 3, 1);
        chk("pre_abort_instret", instret, 32'd5);
        do_reset();

        for (int n = 0; n < 40; n++) begin
            o  = ops[$urandom_range(0, 7)];
            f3 = 3'($urandom_range(0, 7));
            f7 = 7'($urandom_range(0, 127));
            if (o == 7'b0110011) f7 = ($urandom_range(0, 1) != 0)
                                     ? 7'b0100000 : 7'b0000000;
            if (o == 7'b0001011) begin
                f7 = 7'($urandom_range(0, 4));
                f3 = 3'($urandom_range(0, 3));
            end
            run_instr(o, f3, f7, 1'($urandom_range(0, 1)), -1, -1, 0);
            if (last_err) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL be clocked by clk, with reset as its reset: asynchronous, active-high.
REQ-002 The block SHALL have the following ports:
- clk  in  1  clock.
- reset  in  1  async active-high reset.
- op  in  7  Instr[6:0].
- funct3  in  3  Instr[14:12].
- funct7  in  7  Instr[31:25].
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  unified memory completes access this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
- IRWrite  out  1  instruction/OldPC register enable.
- RegWrite  out  1  register file write enable.
- MemWrite  out  1  memory write strobe.
- ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult.
- ALUSrcA  out  2  ALU A select: 00=PC, 01=OldPC, 10=rs1.
- ALUSrcB  out  2  ALU B select: 00=rs2, 01=ImmExt, 10=4.
- ImmSrc  out  2  immediate format: 00=I, 01=S, 10=B, 11=J.
- ALUControl  out  5  ALU operation.
- illegal  out  1  sticky unimplemented-instruction flag.
- instret  out  32  retired-instruction counter.
- state  out  4  current FSM state, for debug.

Function
REQ-003 The FSM SHALL have states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, ERR.
REQ-004 FETCH SHALL drive AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. It SHALL hold while mem_ready=0, and SHALL assert IRWrite=PCWrite=1 only in the cycle mem_ready=1, then go to DECODE.
REQ-005 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, ImmSrc=10, add. Next state by op:
- 0000011 or 0100011 -> MEMADR.
- 0110011 or 0001011 -> EXECR.
- 0010011 -> EXECI.
- 1100011 -> BEQ.
- 1101111 -> JAL.
- any other op -> ERR.
REQ-006 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, add, ImmSrc=00 (lw) or 01 (sw). Next state: MEMREAD for lw, MEMWRITE for sw.
REQ-007 MEMREAD SHALL drive AdrSrc=1, ResultSrc=00, and hold until mem_ready=1, then go to MEMWB.
REQ-008 MEMWB SHALL drive ResultSrc=01, RegWrite=1, then go to FETCH.
REQ-009 MEMWRITE SHALL drive AdrSrc=1 and MemWrite=1 every cycle in the state, hold until mem_ready=1, then go to FETCH.
REQ-010 EXECR SHALL drive ALUSrcA=10, ALUSrcB=00 with funct decode. EXECI SHALL drive ALUSrcA=10, ALUSrcB=01, ImmSrc=00 with funct decode. Both SHALL then go to ALUWB.
REQ-011 ALUWB SHALL drive ResultSrc=00, RegWrite=1, then go to FETCH.
REQ-012 BEQ SHALL drive ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=Zero, then go to FETCH.
REQ-013 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, ImmSrc=11, then go to ALUWB.
REQ-014 ALU encodings SHALL be: add 00000, sub 00001, and 00010, or 00011, slt 00101.
REQ-015 Funct decode for opcode 0110011/0010011 SHALL map funct3 as follows:
- 000 -> add; sub only if op[5]=1 and funct7[5]=1.
- 010 -> slt.
- 110 -> or.
- 111 -> and.
- any other funct3 -> ERR instead of ALUWB.
REQ-016 Opcode 0001011 SHALL decode {funct7,funct3} as follows, and any other combination SHALL go to ERR:
- 0000000_000 -> 10000 (ANDN).
- 0000000_001 -> 10001 (ORN).
- 0000000_010 -> 10010 (XNOR).
- 0000001_000 -> 10011 (MIN).
- 0000001_001 -> 10100 (MAX).
- 0000001_010 -> 10101 (MINU).
- 0000001_011 -> 10110 (MAXU).
- 0000010_000 -> 10111 (ROL).
- 0000010_001 -> 11000 (ROR).
- 0000011_000 -> 11001 (ABS).
REQ-017 ERR SHALL be terminal until reset, with illegal=1 and all write enables 0.
REQ-018 Write enables not listed for a state SHALL be 0, and all other unlisted selects SHALL be 0.
REQ-019 instret SHALL increment by 1, wrapping at 2^32, on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
REQ-020 All outputs SHALL be Moore outputs of state, except these Mealy terms: IRWrite, PCWrite in FETCH and BEQ, and the state-advance conditions.

Reset
REQ-021 Asserting reset SHALL immediately set state=FETCH, instret=0, illegal=0, at any point including mid-MEMREAD or mid-MEMWRITE.
REQ-022 While reset is high, PCWrite, IRWrite, RegWrite and MemWrite SHALL be forced to 0.

Structure
REQ-023 Package mc_pkg SHALL hold the state enum, opcode constants, and ALUControl localparams.
REQ-024 Sub-module mc_aludec SHALL map (op, funct3, funct7) to ALUControl plus a valid bit; the FSM SHALL instantiate it.

Verification
REQ-025 Reset, then lw (op=0000011), mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; RegWrite=1 only in MEMWB; instret=1.
REQ-026 beq with Zero=1 in BEQ -> PCWrite=1, ALUControl=00001; repeat with Zero=0 -> PCWrite=0; instret increments in both cases.
REQ-027 op=0001011 with funct7=0000010, funct3=001 -> EXECR ALUControl=11000. With 0000011/000 -> 11001. With 0000100/000 -> ERR, illegal=1 held over 10 cycles.
REQ-028 mem_ready=0 for 3 cycles in FETCH -> state held, IRWrite=PCWrite=0; then mem_ready=1 -> IRWrite=1 for exactly one cycle.
REQ-029 sw with mem_ready=0 for 2 cycles in MEMWRITE -> MemWrite=1 for 3 cycles; instret increments exactly once.
REQ-030 reset asserted mid-MEMREAD with instret=5 -> state=FETCH and instret=0 without waiting for a clock edge.
